sequential_subtractor_8bit: RTL and testbench

Multi-cycle 8-bit subtractor with borrow: Diff = A - B - Bin. This is the difference-side counterpart of the team's 8-bit carry-lookahead adder. It reuses one 4-bit slice over two cycles (low nibble, then high nibble), chaining the borrow through a register. A start/ready/done handshake lets it sit on the datapath under a controller FSM. It also reports zero, negative and signed-overflow flags for compare/branch logic.

---
 rtl/sequential_subtractor_8bit_pkg.sv | 19 +
 rtl/sequential_subtractor_8bit_nibble_subtract_4bit.sv | 17 +
 rtl/sequential_subtractor_8bit.sv | 111 +++++++++++
 tb/tb_sequential_subtractor_8bit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequential_subtractor_8bit_pkg.sv
// Shared constants, FSM encoding and flag helper for the multi-cycle 8-bit subtractor.
package sequential_subtractor_8bit_pkg;

    localparam int WIDTH = 8;
    localparam int SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Overflow on subtraction: operands of opposite sign and the result took the sign of B.
    function automatic logic signedOverflow(input logic aMsb, input logic bMsb, input logic dMsb);
        return (aMsb != bMsb) && (dMsb != aMsb);
    endfunction

endpackage

// File: rtl/sequential_subtractor_8bit_nibble_subtract_4bit.sv
// Combinational 4-bit subtract slice: s = a + ~b + cin, with the carry taken from bit 4.
module nibble_subtract_4bit
    import sequential_subtractor_8bit_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] sum;

    assign sum       = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
    assign {cout, s} = sum;

endmodule

// File: rtl/sequential_subtractor_8bit.sv
// Two-cycle 8-bit subtractor with borrow: one shared nibble slice, start/ready/done handshake.
module sequential_subtractor_8bit
    import sequential_subtractor_8bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);

    state_t           state;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opBin;
    logic [SLICE-1:0] lowNibble;
    logic             carryReg;

    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic [SLICE-1:0] sliceS;
    logic             sliceCin;
    logic             sliceCout;
    logic [WIDTH-1:0] fullDiff;

    // The slice sees the low nibble with carry ~Bin, except in HIGH where it takes the high nibble and registered carry.
    always_comb begin
        sliceA   = opA[SLICE-1:0];
        sliceB   = opB[SLICE-1:0];
        sliceCin = ~opBin;
        if (state == HIGH) begin
            sliceA   = opA[WIDTH-1:SLICE];
            sliceB   = opB[WIDTH-1:SLICE];
            sliceCin = carryReg;
        end
    end

    nibble_subtract_4bit slice (
        .a    (sliceA),
        .b    (sliceB),
        .cin  (sliceCin),
        .s    (sliceS),
        .cout (sliceCout)
    );

    assign fullDiff = {sliceS, lowNibble};

    // Control FSM; results and flags load together on HIGH->DONE so no partial nibble is ever visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            opA       <= '0;
            opB       <= '0;
            opBin     <= 1'b0;
            lowNibble <= '0;
            carryReg  <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            Zero      <= 1'b0;
            Neg       <= 1'b0;
            Ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opA   <= A;
                        opB   <= B;
                        opBin <= Bin;
                        ready <= 1'b0;
                        state <= LOW;
                    end
                end
                LOW: begin
                    lowNibble <= sliceS;
                    carryReg  <= sliceCout;
                    state     <= HIGH;
                end
                HIGH: begin
                    Diff  <= fullDiff;
                    Bout  <= ~sliceCout;
                    Zero  <= (fullDiff == '0);
                    Neg   <= fullDiff[WIDTH-1];
                    Ovf   <= signedOverflow(opA[WIDTH-1], opB[WIDTH-1], fullDiff[WIDTH-1]);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_subtractor_8bit.sv
// Scoreboard bench: driver pushes reference results on each accepted start, a negedge monitor pops and compares.
module tb_sequential_subtractor_8bit;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       neg;
        logic       ovf;
        int         acceptCyc;
    } result_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       ready;
    logic       done;
    logic [7:0] Diff;
    logic       Bout;
    logic       Zero;
    logic       Neg;
    logic       Ovf;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    logic    rstApplied = 1'b0;
    bit      monitorOn = 1'b0;
    result_t expQ[$];
    result_t held;

    sequential_subtractor_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .ready (ready),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout),
        .Zero  (Zero),
        .Neg   (Neg),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rstApplied <= rst;
    end

    // Reference: plain integer arithmetic, signed overflow judged by whether the true result fits in 8 bits.
    function automatic result_t refModel(input logic [7:0] a, input logic [7:0] b, input logic bin);
        result_t r;
        int raw;
        int sres;
        raw    = int'(a) - int'(b) - int'(bin);
        sres   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.diff = 8'(raw);
        r.bout = (raw < 0);
        r.zero = (r.diff == 8'h00);
        r.neg  = r.diff[7];
        r.ovf  = (sres < -128) || (sres > 127);
        r.acceptCyc = 0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: reset clears the scoreboard, done pops and compares, otherwise outputs must hold.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (rstApplied) begin
                expQ.delete();
                held = '{diff: 8'h00, bout: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0, acceptCyc: 0};
                checkOutput("rst_ready", {31'b0, ready}, 32'd1);
                checkOutput("rst_done", {31'b0, done}, 32'd0);
                checkOutput("rst_diff", {24'b0, Diff}, 32'd0);
                checkOutput("rst_flags", {28'b0, Bout, Zero, Neg, Ovf}, 32'd0);
            end else if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
                end else begin
                    held = expQ.pop_front();
                    checkOutput("diff", {24'b0, Diff}, {24'b0, held.diff});
                    checkOutput("bout", {31'b0, Bout}, {31'b0, held.bout});
                    checkOutput("zero", {31'b0, Zero}, {31'b0, held.zero});
                    checkOutput("neg", {31'b0, Neg}, {31'b0, held.neg});
                    checkOutput("ovf", {31'b0, Ovf}, {31'b0, held.ovf});
                    checkOutput("latency", cyc - held.acceptCyc, 32'd2);
                    checkOutput("done_ready", {31'b0, ready}, 32'd0);
                end
            end else begin
                checkOutput("hold_diff", {24'b0, Diff}, {24'b0, held.diff});
                checkOutput("hold_flags", {28'b0, Bout, Zero, Neg, Ovf},
                            {28'b0, held.bout, held.zero, held.neg, held.ovf});
                checkOutput("busy_ready", {31'b0, ready}, (expQ.size() == 0) ? 32'd1 : 32'd0);
            end
        end
    end

    // Waits at negedges for ready, bounded; reports a failure if it never comes.
    task automatic waitReady(output bit ok);
        int guard = 0;
        while (ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = (ready === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: got ready=%b, expected 1 within 20 cycles", ready);
        end
    endtask

    // Issues one operation; with disturb set, scrambles operands and pulses start during LOW/HIGH/DONE.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit disturb);
        bit      ok;
        result_t e;
        waitReady(ok);
        if (ok) begin
            A = a;
            B = b;
            Bin = bin;
            start = 1'b1;
            @(posedge clk);
            #1;
            e = refModel(a, b, bin);
            e.acceptCyc = cyc;
            expQ.push_back(e);
            @(negedge clk);
            start = 1'b0;
            if (disturb) begin
                repeat (3) begin
                    A = 8'($urandom_range(0, 255));
                    B = 8'($urandom_range(0, 255));
                    Bin = 1'($urandom_range(0, 1));
                    start = 1'b1;
                    @(negedge clk);
                end
                start = 1'b0;
            end
        end
    endtask

    // start held high: exactly one acceptance per IDLE visit, so accepts are 4 cycles apart.
    task automatic startBurst(input int n);
        bit      ok;
        int      prevAccept = 0;
        result_t e;
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            waitReady(ok);
            if (!ok) break;
            A = 8'($urandom_range(0, 255));
            B = 8'($urandom_range(0, 255));
            Bin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            e = refModel(A, B, Bin);
            e.acceptCyc = cyc;
            expQ.push_back(e);
            if (i > 0) checkOutput("burst_spacing", cyc - prevAccept, 32'd4);
            prevAccept = cyc;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        rst = 1'b1;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        monitorOn = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'h50, 8'h20, 1'b0, 1'b0);
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h05, 8'h04, 1'b1, 1'b0);
        applyStimulus(8'h3C, 8'h3C, 1'b1, 1'b0);
        applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h9A, 8'h35, 1'b1, 1'b1);
        applyStimulus(8'h01, 8'h80, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        startBurst(6);

        // Reset while an operation sits in LOW, with start raised on the same edge.
        applyStimulus(8'hC3, 8'h21, 1'b0, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        A = 8'h44;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Reset and start together in IDLE: the start must not be accepted.
        applyStimulus(8'h66, 8'h11, 1'b0, 1'b0);
        waitReady(ok);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("rst_start_ignored", {31'b0, ready}, 32'd1);
        rst = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clk);

        applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("pending_results", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
